arp_tx: RTL and testbench
=========================

// Module: arp_tx
// PURPOSE
//  GMII-side ARP frame transmitter: builds and sends a complete ARP request or reply (preamble, SFD,
//  Ethernet header, 28B ARP body, 18B zero pad, FCS). Sits downstream of the ARP receive parser:
//  consumes the parsed peer MAC/IP and request/reply indication, drives gmii_tx_en/gmii_txd.
//  Frame on wire = 8+14+46+4 = 72 bytes; FCS by sub-module crc32_d8.
// PARAMETERS
//  BOARD_MAC  48'h00_11_22_33_44_55       local MAC (eth src, ARP sender HW addr)
//  BOARD_IP   {8'd192,8'd168,8'd0,8'd5}   local IP (ARP sender protocol addr)
//  IFG_BYTES  12                          idle cycles after FCS before next frame may start
// PORTS
//  gmii_txc     in   1   TX byte clock; all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  arp_tx_en    in   1   one-cycle start pulse (sampled only in IDLE)
//  arp_tx_type  in   1   0 = send request, 1 = send reply
//  des_mac      in   48  peer MAC (reply: eth dst + target HW addr; ignored for request)
//  des_ip       in   32  peer IP (ARP target protocol addr)
//  arp_rx_done  in   1   parser done pulse (used only with ARP_AUTO_REPLY_EN)
//  arp_rx_type  in   1   parser type, 0 = request received (used only with ARP_AUTO_REPLY_EN)
//  gmii_tx_en   out  1   byte valid to PHY
//  gmii_txd     out  8   byte to PHY
//  tx_busy      out  1   high from start-sample edge through end of IFG
//  arp_tx_done  out  1   one-cycle pulse after last FCS byte
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, gmii_tx_en=0, gmii_txd=0, tx_busy=0, arp_tx_done=0, counter 0.
//  Start: in IDLE, edge sampling arp_tx_en=1 latches arp_tx_type/des_mac/des_ip, sets tx_busy,
//   enters PRE_DATA; first byte (8'h55) with gmii_tx_en=1 appears on the NEXT edge (1-cycle latency).
//  All outputs registered. gmii_tx_en high exactly 72 consecutive cycles.
//  FSM: IDLE->PRE_DATA(8: 7x55,D5)->ETH_HEAD(14)->ARP_DATA(46)->CRC(4)->IFG(IFG_BYTES)->IDLE.
//  ETH_HEAD: dst = req ? FF:FF:FF:FF:FF:FF : des_mac; src = BOARD_MAC; type 08 06.
//  ARP_DATA bytes 0-27: 0001 0800 06 04, op 0001(req)/0002(reply), BOARD_MAC, BOARD_IP,
//   target HW = req ? 0 : des_mac, des_ip; bytes 28-45 = 8'h00. Multi-byte fields MSB first.
//  CRC: CRC-32 poly 04C11DB7 reflected, init FFFFFFFF, over ETH_HEAD+ARP_DATA (60B), result
//   bit-inverted, sent low byte first; crc cleared in IDLE/PRE_DATA.
//  arp_tx_done pulses on the cycle gmii_tx_en first returns low; tx_busy drops when IFG ends.
//  Triggers while tx_busy=1 are dropped (no queue); latched fields frozen for whole frame.
//  Byte counter 7 bits, cleared on every state change; never wraps inside a state.
//  Reset mid-frame: gmii_tx_en low immediately (async), no done pulse, frame truncated.
// CONFIGURATION
//  ARP_AUTO_REPLY_EN defined: in IDLE, arp_rx_done=1 && arp_rx_type=0 also starts a REPLY
//   using des_mac/des_ip; if arp_tx_en is high the same cycle, arp_tx_en and its type win.
//  Not defined: arp_rx_done/arp_rx_type ignored (ports kept, unconnected internally); only
//   arp_tx_en starts frames.
// STRUCTURE
//  Shared package/header: state encodings (one-hot, 6 states), ETH_TYPE_ARP=16'h0806,
//   ARP_OP_REQ=16'h0001, ARP_OP_REPLY=16'h0002, PREAMBLE=8'h55, SFD=8'hD5, CRC_INIT=32'hFFFFFFFF.
//  Sub-module crc32_d8: ports clk, rst_n, data[7:0], crc_en, crc_clr, crc_out[31:0];
//   8-bit-parallel update, registered state.
// TESTING
//  1 Reply: des_mac=48'h10_20_30_40_50_60, des_ip=192.168.0.2, type=1, pulse en -> 72 bytes,
//    dst=102030405060, op=0002, target MAC/IP match, gmii_tx_en up 1 cycle after sample.
//  2 Request: type=0 -> dst FF..FF, op=0001, target HW 00..00, bytes 50-67 of frame all 00.
//  3 FCS: bench CRC model over 60B matches 4 FCS bytes; reflected register before final XOR
//    over 60B+FCS = 32'hDEBB20E3.
//  4 Busy: second arp_tx_en 10 cycles into frame -> ignored; next en right after tx_busy falls
//    -> new frame, spacing >= 12 idle cycles; one arp_tx_done per frame.
//  5 Reset: assert rst_n=0 at byte 30 -> gmii_tx_en=0 same cycle, no done; after release en works.
//  6 ARP_AUTO_REPLY_EN: arp_rx_done with arp_rx_type=0 -> reply sent; arp_rx_type=1 -> nothing;
//    macro off -> no frame for either.

Source files
------------

// File: rtl/arp_tx_pkg.sv
// Shared definitions for the ARP transmitter: one-hot state encoding, frame constants
// and the byte-wide reflected CRC-32 update used by crc32_d8.
package arp_tx_pkg;

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_PRE  = 6'b000010,
        S_ETH  = 6'b000100,
        S_ARP  = 6'b001000,
        S_CRC  = 6'b010000,
        S_IFG  = 6'b100000
    } state_e;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY = 16'h0002;
    localparam logic [15:0] ARP_HW_ETH   = 16'h0001;
    localparam logic [15:0] ARP_PROTO_IP = 16'h0800;
    localparam logic [7:0]  PREAMBLE     = 8'h55;
    localparam logic [7:0]  SFD          = 8'hD5;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;

    localparam logic [6:0]  PRE_LEN      = 7'd8;
    localparam logic [6:0]  ETH_LEN      = 7'd14;
    localparam logic [6:0]  ARP_LEN      = 7'd46;
    localparam logic [6:0]  ARP_BODY_LEN = 7'd28;
    localparam logic [6:0]  FCS_LEN      = 7'd4;

    // Eight LSB-first serial steps of the reflected CRC-32, unrolled into one byte update.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY_REF;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/arp_tx_crc32_d8.sv
// Byte-parallel Ethernet CRC-32 accumulator (reflected, init all-ones, no final inversion).
module crc32_d8
    import arp_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Clear has priority over accumulate.
    always_comb begin
        crc_d = crc_q;
        if (crc_clr) begin
            crc_d = CRC_INIT;
        end else if (crc_en) begin
            crc_d = crc32_next(crc_q, data);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/arp_tx.sv
// GMII ARP request/reply transmitter producing a full 72-byte frame with FCS.
// Optional ARP_AUTO_REPLY_EN: answer parsed ARP requests automatically from IDLE.
module arp_tx
    import arp_tx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd5},
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic        gmii_txc,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        arp_tx_done
);

    localparam logic [6:0] IFG_LAST = 7'(IFG_BYTES - 1);

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        type_q, type_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        start_s, start_type_s, last_s;
    logic [7:0]  byte_s;
    logic [31:0] crc_s, fcs_sh_s;
    logic [111:0] eth_hdr_s, eth_sh_s;
    logic [223:0] arp_body_s, arp_sh_s;

`ifdef ARP_AUTO_REPLY_EN
    assign start_s      = arp_tx_en | (arp_rx_done & ~arp_rx_type);
    assign start_type_s = arp_tx_en ? arp_tx_type : 1'b1;
`else
    logic unused_rx_s;
    assign unused_rx_s  = arp_rx_done ^ arp_rx_type;
    assign start_s      = arp_tx_en;
    assign start_type_s = arp_tx_type;
`endif

    assign eth_hdr_s  = {(type_q ? mac_q : 48'hFFFF_FFFF_FFFF), BOARD_MAC, ETH_TYPE_ARP};
    assign arp_body_s = {ARP_HW_ETH, ARP_PROTO_IP, 8'h06, 8'h04,
                         (type_q ? ARP_OP_REPLY : ARP_OP_REQ), BOARD_MAC, BOARD_IP,
                         (type_q ? mac_q : 48'h0000_0000_0000), ip_q};
    assign eth_sh_s   = eth_hdr_s << {cnt_q, 3'b000};
    assign arp_sh_s   = arp_body_s << {cnt_q, 3'b000};
    assign fcs_sh_s   = ~crc_s >> {cnt_q[1:0], 3'b000};

    // Byte to put on the wire for the current state/position.
    always_comb begin
        byte_s = 8'h00;
        case (state_q)
            S_PRE:   byte_s = (cnt_q == PRE_LEN - 7'd1) ? SFD : PREAMBLE;
            S_ETH:   byte_s = eth_sh_s[111:104];
            S_ARP: begin
                if (cnt_q < ARP_BODY_LEN) begin
                    byte_s = arp_sh_s[223:216];
                end else begin
                    byte_s = 8'h00;
                end
            end
            S_CRC:   byte_s = fcs_sh_s[7:0];
            default: byte_s = 8'h00;
        endcase
    end

    // Next-state, counter, field latch and registered-output logic.
    always_comb begin
        state_d = state_q;
        last_s  = 1'b0;
        type_d  = type_q;
        mac_d   = mac_q;
        ip_d    = ip_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_PRE;
                    type_d  = start_type_s;
                    mac_d   = des_mac;
                    ip_d    = des_ip;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                last_s  = (cnt_q == PRE_LEN - 7'd1);
                state_d = last_s ? S_ETH : S_PRE;
            end
            S_ETH: begin
                last_s  = (cnt_q == ETH_LEN - 7'd1);
                state_d = last_s ? S_ARP : S_ETH;
            end
            S_ARP: begin
                last_s  = (cnt_q == ARP_LEN - 7'd1);
                state_d = last_s ? S_CRC : S_ARP;
            end
            S_CRC: begin
                last_s  = (cnt_q == FCS_LEN - 7'd1);
                state_d = last_s ? S_IFG : S_CRC;
            end
            S_IFG: begin
                last_s  = (cnt_q == IFG_LAST);
                state_d = last_s ? S_IDLE : S_IFG;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = 7'd0;
        end else begin
            cnt_d = cnt_q + 7'd1;
        end

        tx_en_d = (state_q == S_PRE) || (state_q == S_ETH) || (state_q == S_ARP) || (state_q == S_CRC);
        txd_d   = tx_en_d ? byte_s : 8'h00;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_IFG) && (cnt_q == 7'd0);
    end

    // State, latched frame fields and registered GMII outputs.
    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            type_q  <= 1'b0;
            mac_q   <= 48'd0;
            ip_q    <= 32'd0;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // CRC advances on the same edge that registers each header/body byte.
    crc32_d8 u_crc (
        .clk     (gmii_txc),
        .rst_n   (rst_n),
        .data    (byte_s),
        .crc_en  ((state_q == S_ETH) || (state_q == S_ARP)),
        .crc_clr ((state_q == S_IDLE) || (state_q == S_PRE)),
        .crc_out (crc_s)
    );

    assign gmii_tx_en  = tx_en_q;
    assign gmii_txd    = txd_q;
    assign tx_busy     = busy_q;
    assign arp_tx_done = done_q;

endmodule

// File: tb/tb_arp_tx.sv
// Scoreboard bench for arp_tx: expected frame bytes are queued at trigger time and
// compared byte-by-byte as the transmitter emits them.
module tb_arp_tx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd5};

    logic        gmii_txc = 1'b0;
    logic        rst_n;
    logic        arp_tx_en, arp_tx_type, arp_rx_done, arp_rx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_tx_en, tx_busy, arp_tx_done;
    logic [7:0]  gmii_txd;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int  idx = 0, run = 0, last_run = 0, gap_cnt = 0, gap_last = 0;
    int  done_cnt = 0, en_total = 0;
    bit  prev_en = 1'b0;

    arp_tx dut (
        .gmii_txc    (gmii_txc),
        .rst_n       (rst_n),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .tx_busy     (tx_busy),
        .arp_tx_done (arp_tx_done)
    );

    always #4 gmii_txc = ~gmii_txc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic string region(input int i);
        if (i < 8)       return "preamble";
        else if (i < 22) return "eth_hdr";
        else if (i < 50) return "arp_body";
        else if (i < 68) return "pad";
        else             return "fcs";
    endfunction

    task automatic push_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0]  fr[72];
        logic [47:0] dst, tmac;
        logic [31:0] c, f;
        dst  = typ ? mac : 48'hFFFF_FFFF_FFFF;
        tmac = typ ? mac : 48'h0;
        for (int i = 0; i < 7; i++) fr[i] = 8'h55;
        fr[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            fr[8 + i]  = dst[47 - 8*i -: 8];
            fr[14 + i] = BOARD_MAC[47 - 8*i -: 8];
            fr[30 + i] = BOARD_MAC[47 - 8*i -: 8];
            fr[40 + i] = tmac[47 - 8*i -: 8];
        end
        fr[20] = 8'h08; fr[21] = 8'h06;
        fr[22] = 8'h00; fr[23] = 8'h01; fr[24] = 8'h08; fr[25] = 8'h00;
        fr[26] = 8'h06; fr[27] = 8'h04; fr[28] = 8'h00; fr[29] = typ ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            fr[36 + i] = BOARD_IP[31 - 8*i -: 8];
            fr[46 + i] = ip[31 - 8*i -: 8];
        end
        for (int i = 50; i < 68; i++) fr[i] = 8'h00;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) c = crc_upd(c, fr[i]);
        f = ~c;
        for (int i = 0; i < 4; i++) fr[68 + i] = f[8*i +: 8];
        for (int i = 0; i < 72; i++) exp_q.push_back(fr[i]);
    endtask

    // Caller sits on a negedge; the DUT samples the trigger on the following posedge.
    task automatic start_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_tx_type = typ; des_mac = mac; des_ip = ip; arp_tx_en = 1'b1;
        push_frame(typ, mac, ip);
        rx_q.delete();
        @(negedge gmii_txc);
        arp_tx_en = 1'b0; arp_tx_type = ~typ; des_mac = ~mac; des_ip = ~ip;
        check("lat_busy", 32'(tx_busy), 32'd1);
        check("lat_en_early", 32'(gmii_tx_en), 32'd0);
        @(negedge gmii_txc);
        check("lat_first_byte", 32'(gmii_tx_en), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < 300) begin
            @(negedge gmii_txc);
            n++;
        end
        check("busy_timeout", 32'(tx_busy), 32'd0);
    endtask

    task automatic frame_checks(input int d0);
        logic [31:0] r;
        check("run_len", 32'(last_run), 32'd72);
        check("done_cnt", 32'(done_cnt - d0), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("rx_len", 32'(rx_q.size()), 32'd72);
        if (rx_q.size() == 72) begin
            r = 32'hFFFFFFFF;
            for (int i = 8; i < 72; i++) r = crc_upd(r, rx_q[i]);
            check("fcs_residue", r, 32'hDEBB20E3);
        end
    endtask

    // Monitor: pops the scoreboard for every valid byte and tracks run/gap/done.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge gmii_txc);
            if (gmii_tx_en === 1'b1) begin
                if (!prev_en) begin
                    gap_last = gap_cnt;
                    idx = 0;
                    run = 0;
                end
                rx_q.push_back(gmii_txd);
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check(region(idx), 32'(gmii_txd), 32'(e));
                end
                idx++; run++; en_total++;
            end else begin
                if (prev_en) last_run = run;
                gap_cnt = prev_en ? 1 : gap_cnt + 1;
            end
            if (arp_tx_done === 1'b1) begin
                done_cnt++;
                check("done_edge", 32'(prev_en && (gmii_tx_en === 1'b0)), 32'd1);
            end
            prev_en = (gmii_tx_en === 1'b1);
        end
    end

    initial begin
        int d0, e0, n;
        arp_tx_en = 1'b0; arp_tx_type = 1'b0; arp_rx_done = 1'b0; arp_rx_type = 1'b0;
        des_mac = 48'h0; des_ip = 32'h0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        check("rst_txd", 32'(gmii_txd), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(arp_tx_done), 32'd0);
        repeat (3) @(negedge gmii_txc);
        rst_n = 1'b1;
        repeat (2) @(negedge gmii_txc);

        // Reply
        d0 = done_cnt;
        start_frame(1'b1, 48'h10_20_30_40_50_60, {8'd192, 8'd168, 8'd0, 8'd2});
        wait_idle();
        frame_checks(d0);

        // Request
        @(negedge gmii_txc);
        d0 = done_cnt;
        start_frame(1'b0, 48'hA1_A2_A3_A4_A5_A6, {8'd192, 8'd168, 8'd0, 8'd77});
        wait_idle();
        frame_checks(d0);

        // Trigger while busy is dropped; next trigger right as busy falls is taken
        @(negedge gmii_txc);
        d0 = done_cnt;
        start_frame(1'b1, 48'h0A_0B_0C_0D_0E_0F, {8'd10, 8'd0, 8'd0, 8'd9});
        repeat (8) @(negedge gmii_txc);
        arp_tx_type = 1'b0; arp_tx_en = 1'b1;
        @(negedge gmii_txc);
        arp_tx_en = 1'b0;
        wait_idle();
        frame_checks(d0);
        d0 = done_cnt;
        start_frame(1'b0, 48'h11_22_33_44_55_66, {8'd172, 8'd16, 8'd3, 8'd4});
        wait_idle();
        frame_checks(d0);
        check("ifg_gap_ge12", 32'(gap_last >= 12), 32'd1);

        // Reset in the middle of a frame
        @(negedge gmii_txc);
        d0 = done_cnt;
        start_frame(1'b1, 48'hDE_AD_BE_EF_00_01, {8'd192, 8'd168, 8'd0, 8'd3});
        n = 0;
        while (idx < 30 && n < 100) begin
            @(negedge gmii_txc);
            #1;
            n++;
        end
        check("reach_byte30", 32'(idx >= 30), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_en", 32'(gmii_tx_en), 32'd0);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge gmii_txc);
        exp_q.delete();
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        rst_n = 1'b1;
        @(negedge gmii_txc);
        d0 = done_cnt;
        start_frame(1'b0, 48'h0, {8'd192, 8'd168, 8'd0, 8'd99});
        wait_idle();
        frame_checks(d0);

        // Parser-driven reply path
        @(negedge gmii_txc);
        d0 = done_cnt; e0 = en_total;
        des_mac = 48'h02_04_06_08_0A_0C; des_ip = {8'd192, 8'd168, 8'd0, 8'd44};
        arp_rx_type = 1'b0; arp_rx_done = 1'b1;
`ifdef ARP_AUTO_REPLY_EN
        push_frame(1'b1, des_mac, des_ip);
        rx_q.delete();
`endif
        @(negedge gmii_txc);
        arp_rx_done = 1'b0;
`ifdef ARP_AUTO_REPLY_EN
        wait_idle();
        frame_checks(d0);
`else
        repeat (120) @(negedge gmii_txc);
        check("auto_off_no_frame", 32'(en_total - e0), 32'd0);
`endif
        @(negedge gmii_txc);
        e0 = en_total;
        arp_rx_type = 1'b1; arp_rx_done = 1'b1;
        @(negedge gmii_txc);
        arp_rx_done = 1'b0;
        repeat (120) @(negedge gmii_txc);
        check("rx_reply_no_frame", 32'(en_total - e0), 32'd0);
        check("final_idle_busy", 32'(tx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
